// File: rtl/ram_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs little-endian words
// into consecutive RAM addresses, verifies the trailing XOR checksum and releases the CPU.
module ram_loader #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int unsigned BYTES  = (WIDTH + 7) / 8;
  localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W  = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam int unsigned TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              we_q, busy_q, done_q, err_q, hold_q;
  logic              accept;

  // Ready only in the byte-consuming states, and never while reset is asserted.
  assign rx_ready = ~rst & ((state_q == S_HDR) | (state_q == S_DATA) | (state_q == S_CSUM));
  assign accept   = rx_valid & rx_ready;

  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_we   = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      addr_q  <= '0;
      din_q   <= '0;
      n_q     <= '0;
      words_q <= '0;
      byte_q  <= '0;
      csum_q  <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      n_q     <= n_d;
      words_q <= words_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
      tmr_q   <= tmr_d;
      we_q    <= (state_d == S_WRITE);
      busy_q  <= (state_d == S_DATA) | (state_d == S_WRITE) | (state_d == S_CSUM);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
      hold_q  <= (state_d != S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    n_d     = n_q;
    words_d = words_q;
    byte_d  = byte_q;
    csum_d  = csum_q;
    tmr_d   = tmr_q;

    if (accept) begin
      tmr_d = '0;
    end

    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          // A zero header means a full-depth load.
          n_d     = (rx_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(rx_data);
          words_d = '0;
          byte_d  = '0;
          csum_d  = '0;
          addr_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // Byte k lands in bits [8k +: 8]; bits beyond WIDTH are discarded.
          for (int b = 0; b < int'(WIDTH); b++) begin
            if ((b / 8) == int'(byte_q)) begin
              din_d[b] = rx_data[3'(b % 8)];
            end
          end
          csum_d = csum_q ^ rx_data;
          if (byte_q == BYTE_W'(BYTES - 1)) begin
            byte_d  = '0;
            state_d = S_WRITE;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end else if (TIMEOUT > 0) begin
          if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + CNT_W'(1);
        state_d = ((words_q + CNT_W'(1)) == n_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end else if (TIMEOUT > 0) begin
          if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: random byte streams driven over valid/ready,
// checked every cycle against a transaction-level model of the load protocol.
module tb_ram_loader;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  ram_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM image and edge-sampled handshake events
  logic [15:0] mem [256];
  int          we_count = 0;
  bit          e_rst = 1'b0;
  bit          e_acc = 1'b0;
  logic [7:0]  e_data = 8'h00;

  always @(posedge clk) begin
    e_rst  <= rst;
    e_acc  <= rx_valid & rx_ready & ~rst;
    e_data <= rx_data;
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_din;
      we_count      <= we_count + 1;
    end
  end

  // Protocol model: updated once per cycle from the events of the last edge
  bit          seen_rst = 1'b0;
  bit          m_active, m_done, m_err, m_we, m_prev_we;
  int          m_n, m_bytes, m_idle, m_addr;
  logic [7:0]  m_csum;
  logic [15:0] m_word, m_din;

  always @(negedge clk) begin
    #1;
    if (e_rst) begin
      seen_rst = 1'b1;
      m_active = 0; m_done = 0; m_err = 0; m_we = 0; m_prev_we = 0;
      m_n = 0; m_bytes = 0; m_idle = 0; m_addr = 0;
      m_csum = 8'h00; m_word = 16'h0000; m_din = 16'h0000;
    end else if (seen_rst) begin
      m_prev_we = m_we;
      m_we      = 0;
      if (m_prev_we) m_addr = (m_addr + 1) % 256;
      if (e_acc) begin
        m_idle = 0;
        if (!m_active) begin
          m_n      = (e_data == 8'h00) ? 256 : int'(e_data);
          m_active = 1;
          m_bytes  = 0;
          m_csum   = 8'h00;
        end else if (m_bytes < 2 * m_n) begin
          if (m_bytes % 2 == 0) m_word[7:0] = e_data;
          else                  m_word[15:8] = e_data;
          m_csum = m_csum ^ e_data;
          m_bytes++;
          if (m_bytes % 2 == 0) begin
            m_we  = 1;
            m_din = m_word;
          end
        end else begin
          if (e_data == m_csum) m_done = 1;
          else                  m_err  = 1;
          m_active = 0;
        end
      end else if (m_active && !m_prev_we) begin
        m_idle++;
        if (TIMEOUT > 0 && m_idle == int'(TIMEOUT)) begin
          m_err    = 1;
          m_active = 0;
        end
      end
    end
    if (seen_rst) begin
      chk("busy",     32'(busy),     32'(m_active));
      chk("done",     32'(done),     32'(m_done));
      chk("err",      32'(err),      32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      chk("ram_we",   32'(ram_we),   32'(m_we));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("rx_ready", 32'(rx_ready), 32'(!rst && !m_done && !m_err && !m_we));
      if (m_we) chk("ram_din", 32'(ram_din), 32'(m_din));
    end
  end

  logic [7:0] stim_q[$];
  logic [7:0] dbytes[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int c = 0; c < 64; c++) begin
      #1;
      got = rx_ready;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL accept_wait: byte %0h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_all(input int maxgap);
    while (stim_q.size() > 0) send_byte(stim_q.pop_front(), $urandom_range(0, maxgap));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_load(input int n, input bit bad, input int maxgap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    dbytes.delete();
    stim_q.delete();
    stim_q.push_back(8'(n % 256));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      dbytes.push_back(b);
      stim_q.push_back(b);
      cs = cs ^ b;
    end
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    stim_q.push_back(cs);
    send_all(maxgap);
    idle(3);
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) chk("mem_word", 32'(mem[i]), 32'({dbytes[2*i+1], dbytes[2*i]}));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    bit bad;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_addr",     32'(ram_addr), 32'h0);
    chk("rst_din",      32'(ram_din),  32'h0);
    chk("rst_we",       32'(ram_we),   32'h0);
    chk("rst_ready",    32'(rx_ready), 32'h0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Known stream, correct checksum
    stim_q = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    send_all(2);
    idle(3);
    chk("t1_mem0", 32'(mem[0]), 32'h1234);
    chk("t1_mem1", 32'(mem[1]), 32'h5678);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_err",  32'(err),  32'h0);
    chk("t1_hold", 32'(cpu_hold), 32'h0);

    // Same stream, bad checksum, valid held high throughout; then bytes offered in ERR
    do_reset();
    base   = we_count;
    stim_q = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
    send_all(0);
    repeat (5) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom_range(0, 255));
    end
    idle(2);
    chk("t2_err",    32'(err),      32'h1);
    chk("t2_done",   32'(done),     32'h0);
    chk("t2_hold",   32'(cpu_hold), 32'h1);
    chk("t2_we_cnt", 32'(we_count - base), 32'd2);
    chk("t2_mem1",   32'(mem[1]),   32'h5678);

    // Full-depth load (header 0)
    do_reset();
    base = we_count;
    run_load(256, 1'b0, 0);
    check_mem(256);
    chk("t4_we_cnt", 32'(we_count - base), 32'd256);
    chk("t4_addr",   32'(ram_addr), 32'h0);
    chk("t4_done",   32'(done), 32'h1);

    // Timeout after three data bytes
    do_reset();
    base   = we_count;
    stim_q = '{8'h02, 8'hA1, 8'hB2, 8'hC3};
    send_all(0);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      #2;
      if (err === 1'b1) begin
        k = c - 1;
        break;
      end
    end
    chk("t5_err_delay", 32'(k), 32'd16);
    idle(3);
    chk("t5_we_cnt", 32'(we_count - base), 32'd1);
    chk("t5_mem0",   32'(mem[0]), 32'hB2A1);

    // Reset in the middle of word 1, then a fresh single-word load
    do_reset();
    stim_q = '{8'h03, 8'h11, 8'h22, 8'h33};
    send_all(0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("t6_busy", 32'(busy),     32'h0);
    chk("t6_we",   32'(ram_we),   32'h0);
    chk("t6_addr", 32'(ram_addr), 32'h0);
    stim_q = '{8'h01, 8'hAB, 8'hCD, 8'h66};
    send_all(1);
    idle(3);
    chk("t6_mem0", 32'(mem[0]), 32'hCDAB);
    chk("t6_done", 32'(done), 32'h1);

    // Random loads with random gaps and random checksum corruption
    for (int r = 0; r < 20; r++) begin
      do_reset();
      n   = $urandom_range(1, 8);
      bad = 1'($urandom_range(0, 1));
      run_load(n, bad, 3);
      check_mem(n);
      chk("rnd_done", 32'(done), 32'(!bad));
      chk("rnd_err",  32'(err),  32'(bad));
      chk("rnd_addr", 32'(ram_addr), 32'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
